// File: rtl/rns_to_int_seq.sv
// rns_to_int_seq: converts a packed four-residue RNS word to its integer value
// using sequential mixed-radix conversion (one digit per cycle).
//
// Parameters:
//   M0..M3    moduli of residue bytes [7:0], [15:8], [23:16], [31:24].
//             They must be pairwise coprime, each in [2,256], and the product
//             must be below 2^32.
// Ports:
//   clk       clock, rising edge
//   reset     synchronous active-high reset
//   in_valid  in_rns holds a valid RNS word
//   in_ready  block accepts in_rns this cycle
//   in_rns    packed residues {r3,r2,r1,r0}
//   out_valid out_data holds a converted result
//   out_ready consumer takes out_data this cycle
//   out_data  converted integer
// Build option:
//   RNS_SIGNED_OUT_EN  when defined, results above (M-1)/2 are output as X-M
//                      (two's complement) instead of unsigned X.
module rns_to_int_seq #(
  parameter int unsigned M0 = 233,
  parameter int unsigned M1 = 239,
  parameter int unsigned M2 = 241,
  parameter int unsigned M3 = 251
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_rns,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  // Multiplicative inverse of a modulo m by search; elaboration-time only.
  function automatic int unsigned f_inv(input int unsigned a, input int unsigned m);
    int unsigned a_red;
    a_red = a % m;
    for (int unsigned i = 1; i < m; i++) begin
      if (((a_red * i) % m) == 1) return i;
    end
    return 0;
  endfunction

  // One mixed-radix step: ((t - a) * inv) mod m, with t already in [0, m-1].
  function automatic logic [7:0] f_step(input int unsigned t, input int unsigned a,
                                        input int unsigned inv, input int unsigned m);
    int unsigned diff;
    diff = t + m - (a % m);
    return 8'((diff * inv) % m);
  endfunction

  localparam logic [63:0] MProd = 64'(M0) * 64'(M1) * 64'(M2) * 64'(M3);

  localparam int unsigned Inv01 = f_inv(M0, M1);
  localparam int unsigned Inv02 = f_inv(M0, M2);
  localparam int unsigned Inv03 = f_inv(M0, M3);
  localparam int unsigned Inv12 = f_inv(M1, M2);
  localparam int unsigned Inv13 = f_inv(M1, M3);
  localparam int unsigned Inv23 = f_inv(M2, M3);

  if (MProd >= 64'h1_0000_0000) begin : g_bad_range
    $fatal(1, "rns_to_int_seq: product of moduli does not fit in 32 bits");
  end
  if (M0 < 2 || M0 > 256 || M1 < 2 || M1 > 256 ||
      M2 < 2 || M2 > 256 || M3 < 2 || M3 > 256) begin : g_bad_modulus
    $fatal(1, "rns_to_int_seq: each modulus must lie in [2,256]");
  end
  if (Inv01 == 0 || Inv02 == 0 || Inv03 == 0 ||
      Inv12 == 0 || Inv13 == 0 || Inv23 == 0) begin : g_not_coprime
    $fatal(1, "rns_to_int_seq: moduli must be pairwise coprime");
  end

  typedef enum logic [2:0] {StIdle, StD1, StD2, StD3, StAcc, StOut} state_e;

  state_e      r_state;
  logic [7:0]  r_a0, r_a1, r_a2, r_a3;  // mixed-radix digits
  logic [7:0]  r_t1, r_t2, r_t3;        // residues, partially reduced in place
  logic        r_out_valid;
  logic [31:0] r_out_data;

  logic        w_xfer;
  logic [7:0]  w_r0, w_r1, w_r2, w_r3;
  logic [7:0]  w_a1, w_t2_d1, w_t3_d1;
  logic [7:0]  w_a2, w_t3_d2;
  logic [7:0]  w_a3;
  logic [31:0] w_x;
  logic [31:0] w_result;

  assign in_ready  = (r_state == StIdle) || ((r_state == StOut) && out_ready);
  assign w_xfer    = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // Residues >= their modulus are folded back into range on capture.
  assign w_r0 = 8'(32'(in_rns[7:0])   % M0);
  assign w_r1 = 8'(32'(in_rns[15:8])  % M1);
  assign w_r2 = 8'(32'(in_rns[23:16]) % M2);
  assign w_r3 = 8'(32'(in_rns[31:24]) % M3);

  // D1 strips a0 from every remaining residue, D2 strips a1, D3 strips a2.
  assign w_a1    = f_step(32'(r_t1), 32'(r_a0), Inv01, M1);
  assign w_t2_d1 = f_step(32'(r_t2), 32'(r_a0), Inv02, M2);
  assign w_t3_d1 = f_step(32'(r_t3), 32'(r_a0), Inv03, M3);
  assign w_a2    = f_step(32'(r_t2), 32'(r_a1), Inv12, M2);
  assign w_t3_d2 = f_step(32'(r_t3), 32'(r_a1), Inv13, M3);
  assign w_a3    = f_step(32'(r_t3), 32'(r_a2), Inv23, M3);

  // Horner form; every partial product stays below M, so 32 bits suffice.
  assign w_x = 32'(r_a0) + M0 * (32'(r_a1) + M1 * (32'(r_a2) + M2 * 32'(r_a3)));

`ifdef RNS_SIGNED_OUT_EN
  localparam logic [31:0] MVal  = MProd[31:0];
  localparam logic [31:0] HalfM = (MVal - 32'd1) >> 1;
  assign w_result = (w_x > HalfM) ? (w_x - MVal) : w_x;
`else
  assign w_result = w_x;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_a0        <= '0;
      r_a1        <= '0;
      r_a2        <= '0;
      r_a3        <= '0;
      r_t1        <= '0;
      r_t2        <= '0;
      r_t3        <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      // Capture only happens in StIdle or StOut, so it never collides with D1..D3.
      if (w_xfer) begin
        r_a0 <= w_r0;
        r_t1 <= w_r1;
        r_t2 <= w_r2;
        r_t3 <= w_r3;
      end
      case (r_state)
        StIdle: begin
          if (w_xfer) r_state <= StD1;
        end
        StD1: begin
          r_a1    <= w_a1;
          r_t2    <= w_t2_d1;
          r_t3    <= w_t3_d1;
          r_state <= StD2;
        end
        StD2: begin
          r_a2    <= w_a2;
          r_t3    <= w_t3_d2;
          r_state <= StD3;
        end
        StD3: begin
          r_a3    <= w_a3;
          r_state <= StAcc;
        end
        StAcc: begin
          r_out_data  <= w_result;
          r_out_valid <= 1'b1;
          r_state     <= StOut;
        end
        StOut: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= in_valid ? StD1 : StIdle;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rns_to_int_seq.sv
module tb_rns_to_int_seq;

  localparam longint unsigned MTot = 64'd3368562317;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_rns;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];

  rns_to_int_seq dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_rns   (in_rns),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result for integer x in [0, M-1].
  function automatic logic [31:0] model(input longint unsigned x);
`ifdef RNS_SIGNED_OUT_EN
    if (x > (MTot - 1) / 2) return 32'(x - MTot);
`endif
    return 32'(x);
  endfunction

  function automatic logic [31:0] pack(input longint unsigned x);
    return {8'(x % 251), 8'(x % 241), 8'(x % 239), 8'(x % 233)};
  endfunction

  task automatic send_word(input logic [31:0] w, output bit ok);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_rns   = w;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the accepting edge until out_valid (bounded).
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 20);
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1;  // reset must win over a transfer
    in_rns = 32'hF7242C44;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'd0)
      begin errors++; $display("FAIL reset_out valid=%b data=%h want 0/0", out_valid, out_data); end
    checks++;
    if (in_ready !== 1'b1)
      begin errors++; $display("FAIL reset_idle in_ready=%b want 1", in_ready); end
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1)
      begin errors++; $display("FAIL post_reset_ready in_ready=%b want 1", in_ready); end
    begin
      int seen = 0;
      for (int k = 0; k < 6; k++) begin
        @(posedge clk);
        #1;
        if (out_valid) seen++;
      end
      checks++;
      if (seen != 0)
        begin errors++; $display("FAIL reset_no_output valid_cycles=%0d want 0", seen); end
    end
  endtask

  task automatic test_known_vectors;
    logic [31:0] words[3];
    logic [31:0] exps[3];
    logic [31:0] exp_v;
    bit ok;
    int lat;
    words[0] = 32'h0000_0000; exps[0] = 32'd0;
    words[1] = 32'hF724_2C44; exps[1] = 32'd1000;
    words[2] = 32'hFAF0_EEE8;
`ifdef RNS_SIGNED_OUT_EN
    exps[2] = 32'hFFFF_FFFF;
`else
    exps[2] = 32'd3368562316;
`endif
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(exps[i]);
      send_word(words[i], ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL vec%0d_accept in_ready=0 want 1", i); end
      wait_out(lat);
      checks++;
      if (lat != 4) begin errors++; $display("FAIL vec%0d_latency got=%0d want 4", i, lat); end
      exp_v = sb_q.pop_front();
      checks++;
      if (out_data !== exp_v)
        begin errors++; $display("FAIL vec%0d_data got=%h want %h", i, out_data, exp_v); end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0)
        begin errors++; $display("FAIL vec%0d_consumed out_valid=%b want 0", i, out_valid); end
    end
  endtask

  task automatic test_random;
    longint unsigned x;
    logic [31:0] w;
    logic [31:0] exp_v;
    int unsigned mods[4];
    bit ok;
    int lat;
    mods[0] = 233; mods[1] = 239; mods[2] = 241; mods[3] = 251;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        // Small x: every residue byte can be pushed above its modulus.
        x = longint'($urandom_range(0, 4));
        w = pack(x);
        for (int j = 0; j < 4; j++) w[8*j +: 8] = w[8*j +: 8] + 8'(mods[j]);
      end else begin
        x = {32'd0, $urandom} % MTot;
        w = pack(x);
      end
      sb_q.push_back(model(x));
      send_word(w, ok);
      wait_out(lat);
      checks++;
      if (!ok || lat != 4)
        begin errors++; $display("FAIL rand%0d_timing accept=%0d lat=%0d want 1/4", i, ok, lat); end
      exp_v = sb_q.pop_front();
      checks++;
      if (out_data !== exp_v)
        begin errors++; $display("FAIL rand%0d_data in=%h got=%h want %h", i, w, out_data, exp_v); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp_v;
    bit ok;
    bit bad;
    int lat;
    int seen;
    @(negedge clk);
    out_ready = 1'b0;
    sb_q.push_back(model(64'd123456789));
    send_word(pack(64'd123456789), ok);
    wait_out(lat);
    checks++;
    if (!ok || lat != 4)
      begin errors++; $display("FAIL bp_timing accept=%0d lat=%0d want 1/4", ok, lat); end
    exp_v = sb_q.pop_front();
    in_valid = 1'b1;  // competing word must not be taken while stalled
    in_rns = 32'h0000_0000;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      bad = (out_valid !== 1'b1) || (out_data !== exp_v) || (in_ready !== 1'b0);
      checks++;
      if (bad)
        begin
          errors++;
          $display("FAIL bp_hold%0d valid=%b data=%h ready=%b want 1/%h/0",
                   k, out_valid, out_data, in_ready, exp_v);
        end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid) seen++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (seen != 0)
      begin errors++; $display("FAIL bp_single_transfer extra_valid=%0d want 0", seen); end
  endtask

  task automatic test_back_to_back;
    int idx[$];
    logic [31:0] got[$];
    bit ready_ok;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_rns = 32'hF724_2C44;
    sb_q.push_back(32'd1000);
    @(posedge clk);
    #1;
    in_rns = 32'h0000_0000;
    sb_q.push_back(32'd0);
    ready_ok = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk);
      #1;
      if (i == 5) in_valid = 1'b0;
      if (out_valid) begin
        idx.push_back(i);
        got.push_back(out_data);
        if (i == 4) ready_ok = (in_ready === 1'b1);
      end
    end
    checks++;
    if (idx.size() != 2)
      begin errors++; $display("FAIL b2b_count got=%0d want 2", idx.size()); end
    checks++;
    if (!ready_ok) begin errors++; $display("FAIL b2b_in_ready got=0 want 1 in OUT"); end
    for (int k = 0; k < 2; k++) begin
      logic [31:0] exp_v;
      int exp_i;
      exp_v = sb_q.pop_front();
      exp_i = (k == 0) ? 4 : 9;
      checks++;
      if (k >= idx.size())
        begin errors++; $display("FAIL b2b_result%0d got=none want %h", k, exp_v); end
      else if (idx[k] != exp_i || got[k] !== exp_v)
        begin
          errors++;
          $display("FAIL b2b_result%0d cycle=%0d data=%h want %0d/%h",
                   k, idx[k], got[k], exp_i, exp_v);
        end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int seen;
    send_word(32'hFAF0_EEE8, ok);  // now in D1; aborted word never enters the scoreboard
    @(posedge clk);
    #1;                            // now in D2
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || in_ready !== 1'b1)
      begin
        errors++;
        $display("FAIL mid_reset valid=%b data=%h ready=%b want 0/0/1",
                 out_valid, out_data, in_ready);
      end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0)
      begin errors++; $display("FAIL mid_reset_aborted valid_cycles=%0d want 0", seen); end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_rns = 32'd0;
    out_ready = 1'b1;
    test_reset();
    test_known_vectors();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0)
      begin errors++; $display("FAIL scoreboard_drain left=%0d want 0", sb_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
